// File: rtl/blackjack_pkg.sv
// blackjack_pkg: shared clocking constants and FSM state types for the BlackJack game blocks.
package blackjack_pkg;
    localparam int CLK_HZ   = 50_000_000;
    localparam int TICK_HZ  = 2000;
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_FIRE,
        S_WAIT_REL
    } hold_state_t;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle registered enable every DIV cycles, with sync clear.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk_50M,
    input  logic i_Reset,
    input  logic i_Clear,
    output logic o_Tick
);
    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] LAST     = PW'(DIV - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 2);
    logic [PW-1:0] r_pre;
    logic          r_tick;
    if (DIV < 2) begin : g_bad_div
        $error("tick_gen: DIV must be at least 2");
    end
    // The tick is registered one count early so it is high exactly while r_pre == LAST.
    always_ff @(posedge clk_50M) begin
        if (i_Reset || i_Clear) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_pre  <= (r_pre == LAST) ? '0 : r_pre + 1'b1;
            r_tick <= (r_pre == PRE_LAST);
        end
    end
    assign o_Tick = r_tick;
endmodule

// File: rtl/reset_hold_ctrl.sv
// reset_hold_ctrl: times a held reset button on a tick enable, fires one pulse after the hold, latches a shuffle seed.
module reset_hold_ctrl
    import blackjack_pkg::*;
#(
    parameter int WIDTH      = 12,
    parameter int TICK_DIV   = blackjack_pkg::TICK_DIV,
    parameter int HOLD_TICKS = 4000
) (
    input  logic             clk_50M,
    input  logic             i_Reset,
    input  logic             i_Btn,
    output logic             o_Tick,
    output logic             o_Holding,
    output logic [WIDTH-1:0] o_Count,
    output logic             o_TwoSec,
    output logic [WIDTH-1:0] o_Seed
);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(HOLD_TICKS - 1);
    hold_state_t      r_state;
    logic [WIDTH-1:0] r_fast;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_seed;
    logic             r_hold;
    logic             r_two;
    logic             w_tick;
    logic             w_press;
    logic             w_done;
    if (HOLD_TICKS < 1 || longint'(HOLD_TICKS) > (64'sd1 <<< WIDTH)) begin : g_bad_hold
        $error("reset_hold_ctrl: HOLD_TICKS must be in 1..2**WIDTH");
    end
    assign w_press = (r_state == S_IDLE) && i_Btn;
    assign w_done  = w_tick && (r_count == CNT_LAST);
    // Clearing on the press edge makes the first tick land exactly TICK_DIV cycles into the hold.
    tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick (
        .clk_50M(clk_50M),
        .i_Reset(i_Reset),
        .i_Clear(w_press),
        .o_Tick (w_tick)
    );
    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
            r_fast  <= '0;
            r_count <= '0;
            r_seed  <= '0;
            r_hold  <= 1'b0;
            r_two   <= 1'b0;
        end else begin
            r_fast <= r_fast + 1'b1;
            r_hold <= 1'b0;
            r_two  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_Btn) begin
                        r_state <= S_HOLD;
                        r_seed  <= r_fast;
                        r_count <= '0;
                        r_hold  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // A release wins over a coincident final tick, so short holds never fire.
                    if (!i_Btn) begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                    end else if (w_done) begin
                        r_state <= S_FIRE;
                        r_two   <= 1'b1;
                    end else begin
                        r_hold <= 1'b1;
                        if (w_tick) r_count <= r_count + 1'b1;
                    end
                end
                S_FIRE: r_state <= S_WAIT_REL;
                S_WAIT_REL: begin
                    if (!i_Btn) begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign o_Tick    = w_tick;
    assign o_Holding = r_hold;
    assign o_Count   = r_count;
    assign o_TwoSec  = r_two;
    assign o_Seed    = r_seed;
endmodule

// File: tb/tb_reset_hold_ctrl.sv
// tb_reset_hold_ctrl: table, directed and random checks of reset_hold_ctrl against an arithmetic reference model.
module tb_reset_hold_ctrl;
    localparam int W  = 4;
    localparam int TD = 4;
    localparam int HT = 8;
    logic         clk_50M;
    logic         i_Reset;
    logic         i_Btn;
    logic         o_Tick;
    logic         o_Holding;
    logic [W-1:0] o_Count;
    logic         o_TwoSec;
    logic [W-1:0] o_Seed;
    int n_tests = 0;
    int n_fail  = 0;
    // Model: edge index m_n; the hold is timed as elapsed edges since the press edge.
    int m_n     = 0;
    int m_fast  = 0;
    int m_start = 0;
    int m_pbase = 0;
    int m_mode  = 0;
    int m_cnt   = 0;
    int m_seed  = 0;
    typedef struct {
        bit rst;
        bit btn;
        int n;
        bit e_hold;
        int e_cnt;
        bit e_two;
    } vec_t;
    vec_t tbl[$];
    reset_hold_ctrl #(
        .WIDTH     (W),
        .TICK_DIV  (TD),
        .HOLD_TICKS(HT)
    ) dut (
        .clk_50M  (clk_50M),
        .i_Reset  (i_Reset),
        .i_Btn    (i_Btn),
        .o_Tick   (o_Tick),
        .o_Holding(o_Holding),
        .o_Count  (o_Count),
        .o_TwoSec (o_TwoSec),
        .o_Seed   (o_Seed)
    );
    initial clk_50M = 1'b0;
    always #5 clk_50M = ~clk_50M;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic model(input bit rst, input bit btn);
        int e;
        m_n++;
        if (rst) begin
            m_mode  = 0;
            m_cnt   = 0;
            m_seed  = 0;
            m_fast  = 0;
            m_pbase = m_n;
        end else begin
            e = m_n - m_start;
            if (m_mode == 0) begin
                if (btn) begin
                    m_mode  = 1;
                    m_start = m_n;
                    m_seed  = m_fast;
                    m_cnt   = 0;
                    m_pbase = m_n;
                end
            end else if (m_mode == 1) begin
                if (!btn) begin
                    m_mode = 0;
                    m_cnt  = 0;
                end else if (e == HT * TD) m_mode = 2;
                else m_cnt = (e / TD < HT - 1) ? e / TD : HT - 1;
            end else if (m_mode == 2) m_mode = 3;
            else if (!btn) begin
                m_mode = 0;
                m_cnt  = 0;
            end
            m_fast = (m_fast + 1) % (1 << W);
        end
    endtask
    task automatic step(input bit rst, input bit btn);
        logic [10:0] act, exp;
        bit m_tick;
        i_Reset = rst;
        i_Btn   = btn;
        @(posedge clk_50M);
        model(rst, btn);
        #1;
        m_tick = ((m_n - m_pbase) % TD) == TD - 1;
        act = {o_Tick, o_Holding, o_Count, o_TwoSec, o_Seed};
        exp = {m_tick, m_mode == 1, W'(m_cnt), m_mode == 2, W'(m_seed)};
        check("cycle {tick,hold,cnt,two,seed}", 32'(act), 32'(exp));
    endtask
    task automatic hold_until_pulse(output int k);
        k = 0;
        do begin
            step(1'b0, 1'b1);
            k++;
        end while (o_TwoSec !== 1'b1 && k < 100);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        int k;
        bit b;
        int run;
        i_Reset = 1'b1;
        i_Btn   = 1'b0;
        tbl.push_back('{1, 0, 2, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 0, 0});
        tbl.push_back('{0, 1, 4, 1, 1, 0});
        tbl.push_back('{0, 1, 27, 1, 7, 0});
        tbl.push_back('{0, 1, 1, 0, 7, 1});
        tbl.push_back('{0, 1, 1, 0, 7, 0});
        tbl.push_back('{0, 1, 10, 0, 7, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 3, 0, 0, 0});
        tbl.push_back('{0, 1, 21, 1, 5, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 32, 1, 7, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 2, 0, 0, 0});
        foreach (tbl[r]) begin
            repeat (tbl[r].n) step(tbl[r].rst, tbl[r].btn);
            check($sformatf("row%0d holding", r), 32'(o_Holding), 32'(tbl[r].e_hold));
            check($sformatf("row%0d count", r), 32'(o_Count), tbl[r].e_cnt);
            check($sformatf("row%0d twosec", r), 32'(o_TwoSec), 32'(tbl[r].e_two));
        end
        step(1'b1, 1'b0);
        check("reset outputs", 32'({o_Tick, o_Holding, o_Count, o_TwoSec, o_Seed}), 32'd0);
        repeat (5) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("seed first press", 32'(o_Seed), 32'd5);
        repeat (15) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("seed wrapped press", 32'(o_Seed), 32'd5);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (25) step(1'b0, 1'b1);
        check("mid count", 32'(o_Count), 32'd6);
        step(1'b1, 1'b1);
        check("mid reset outputs", 32'({o_Tick, o_Holding, o_Count, o_TwoSec, o_Seed}), 32'd0);
        hold_until_pulse(k);
        check("pulse after reset", k, 33);
        check("count at pulse", 32'(o_Count), 32'd7);
        repeat (2) step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        hold_until_pulse(k);
        check("re-arm pulse", k, 33);
        step(1'b0, 1'b1);
        check("pulse one cycle", 32'(o_TwoSec), 32'd0);
        b   = 1'b0;
        run = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                b   = !b;
                run = b ? int'($urandom_range(1, 45)) : int'($urandom_range(1, 8));
            end
            run--;
            step($urandom_range(0, 299) == 0, b);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
